// File: rtl/r2r_pwm_decoder.sv
// r2r_pwm_decoder: rebuilds the {r2r, pwm duty} DAC word from the DAC outputs, one frame at a time
// Ports: clk, rstn (async active-low); frame_sync marks cycle 0 of each frame; r2r_in is the R2R code;
// pwm_in is the PWM bit; val_valid pulses one cycle when val_out = {r2r, duty} updates;
// locked is high while syncs arrive every 2**PWM_BITS cycles; frame_err pulses on an early or missing sync;
// sat is set with val_out when the duty count reaches N and is clipped to N-1.
// Option R2R_PWM_DEC_STABLE_CHK_EN adds r2r_err, published with val_out, set when r2r_in moved mid-frame.
module r2r_pwm_decoder #(
  parameter int R2R_BITS = 4,
  parameter int PWM_BITS = 12
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         frame_sync,
  input  logic [R2R_BITS-1:0]          r2r_in,
  input  logic                         pwm_in,
  output logic                         val_valid,
  output logic [R2R_BITS+PWM_BITS-1:0] val_out,
  output logic                         locked,
  output logic                         frame_err,
  output logic                         sat
`ifdef R2R_PWM_DEC_STABLE_CHK_EN
  ,
  output logic                         r2r_err
`endif
);
  localparam logic [PWM_BITS-1:0] LAST = '1;
  localparam logic [PWM_BITS:0] FULL = {1'b1, {PWM_BITS{1'b0}}};
  typedef enum logic {IDLE, ACQ} state_t;
  state_t state;
  logic [PWM_BITS-1:0] pos;
  logic [PWM_BITS:0] hcnt, fin;
  logic [R2R_BITS-1:0] r2r_cap;
  logic start;
`ifdef R2R_PWM_DEC_STABLE_CHK_EN
  logic moved;
`endif
  assign fin = hcnt + {{PWM_BITS{1'b0}}, pwm_in};
  // pos is the index of the current cycle; pos==0 while in ACQ is the expected sync slot after a publish
  assign start = frame_sync && (state == IDLE || pos != LAST);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      pos       <= '0;
      hcnt      <= '0;
      r2r_cap   <= '0;
      val_valid <= 1'b0;
      val_out   <= '0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
      sat       <= 1'b0;
`ifdef R2R_PWM_DEC_STABLE_CHK_EN
      moved     <= 1'b0;
      r2r_err   <= 1'b0;
`endif
    end else begin
      val_valid <= 1'b0;
      frame_err <= 1'b0;
      if (start) begin
        state   <= ACQ;
        pos     <= PWM_BITS'(1);
        r2r_cap <= r2r_in;
        hcnt    <= {{PWM_BITS{1'b0}}, pwm_in};
`ifdef R2R_PWM_DEC_STABLE_CHK_EN
        moved   <= 1'b0;
`endif
        if (state == ACQ) begin
          locked    <= pos == '0;
          frame_err <= pos != '0;
        end
      end else if (state == ACQ) begin
        if (pos == '0) begin
          state     <= IDLE;
          locked    <= 1'b0;
          frame_err <= 1'b1;
        end else begin
          pos  <= pos + 1'b1;
          hcnt <= fin;
`ifdef R2R_PWM_DEC_STABLE_CHK_EN
          moved <= moved | (r2r_in != r2r_cap);
`endif
          if (pos == LAST) begin
            val_valid <= 1'b1;
            sat       <= fin == FULL;
            val_out   <= {r2r_cap, fin == FULL ? LAST : fin[PWM_BITS-1:0]};
`ifdef R2R_PWM_DEC_STABLE_CHK_EN
            r2r_err   <= moved | (r2r_in != r2r_cap);
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_r2r_pwm_decoder.sv
// tb_r2r_pwm_decoder: random frame streams against a frame-level reference model
module tb_r2r_pwm_decoder;
  logic clk = 1'b0, rstn = 1'b0, frame_sync = 1'b0, pwm_in = 1'b0;
  logic [3:0] r2r_in = '0;
  logic val_valid, locked, frame_err, sat, r2r_err;
  logic [7:0] val_out;
  int n_vec = 0, n_bad = 0;
  logic s_sync[0:4095], s_pwm[0:4095];
  logic [3:0] s_r2r[0:4095];
  int T;
  int syncs[$];
  logic e_pub[0:4096], e_err[0:4096], e_sat[0:4096], e_mm[0:4096];
  int e_lk[0:4096];
  logic [7:0] e_w[0:4096];

  r2r_pwm_decoder #(.R2R_BITS(4), .PWM_BITS(4)) dut (
    .clk(clk), .rstn(rstn), .frame_sync(frame_sync), .r2r_in(r2r_in), .pwm_in(pwm_in),
    .val_valid(val_valid), .val_out(val_out), .locked(locked), .frame_err(frame_err), .sat(sat)
`ifdef R2R_PWM_DEC_STABLE_CHK_EN
    , .r2r_err(r2r_err)
`endif
  );
`ifndef R2R_PWM_DEC_STABLE_CHK_EN
  assign r2r_err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) begin
      s_sync[T] = 1'b0; s_r2r[T] = 4'($urandom); s_pwm[T] = 1'($urandom); T++;
    end
  endtask

  // mode: 0 random pwm, 1 five highs, 2 all low, 3 all high, 4 random pwm with r2r bumped from cycle 4
  task automatic add_seg(input int g, input logic [3:0] r, input int mode);
    syncs.push_back(T);
    for (int k = 0; k < g; k++) begin
      s_sync[T] = k == 0;
      s_r2r[T] = (mode == 4 && k >= 4) ? r + 4'd1 : r;
      s_pwm[T] = mode == 1 ? k < 5 : mode == 2 ? 1'b0 : mode == 3 ? 1'b1 : 1'($urandom);
      T++;
    end
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      int r = $urandom_range(0, 9);
      add_seg(r < 6 ? 16 : r < 8 ? $urandom_range(1, 14) : $urandom_range(17, 24),
              4'($urandom), $urandom_range(0, 4) == 4 ? 4 : 0);
    end
  endtask

  // Expected outputs at sampled cycle c, derived from the spacing between consecutive syncs
  task automatic build_exp();
    for (int c = 0; c <= T; c++) begin
      e_pub[c] = 0; e_err[c] = 0; e_lk[c] = -1;
    end
    for (int i = 0; i < syncs.size(); i++) begin
      int s = syncs[i];
      int nxt = i + 1 < syncs.size() ? syncs[i+1] : -1;
      if (nxt >= 0 && nxt - s < 16) begin
        if (nxt + 1 <= T) begin e_err[nxt+1] = 1; e_lk[nxt+1] = 0; end
      end else if (s + 16 <= T) begin
        int cnt = 0;
        logic mm = 0;
        for (int k = 0; k < 16; k++) begin
          cnt += int'(s_pwm[s+k]);
          if (k > 0 && s_r2r[s+k] != s_r2r[s]) mm = 1;
        end
        e_pub[s+16] = 1;
        e_w[s+16] = {s_r2r[s], cnt >= 16 ? 4'hF : 4'(cnt)};
        e_sat[s+16] = cnt == 16;
        e_mm[s+16] = mm;
        if (s + 17 <= T) begin
          if (nxt == s + 16) e_lk[s+17] = 1;
          else begin e_lk[s+17] = 0; e_err[s+17] = 1; end
        end
      end
    end
  endtask

  task automatic run_stream();
    logic [7:0] hw = '0;
    logic hs = 0, hm = 0, hl = 0;
    build_exp();
    for (int t = 0; t < T; t++) begin
      frame_sync = s_sync[t]; r2r_in = s_r2r[t]; pwm_in = s_pwm[t];
      @(posedge clk);
      #1;
      if (e_pub[t+1]) begin hw = e_w[t+1]; hs = e_sat[t+1]; hm = e_mm[t+1]; end
      if (e_lk[t+1] >= 0) hl = e_lk[t+1] == 1;
      chk("val_valid", 32'(val_valid), 32'(e_pub[t+1]));
      chk("frame_err", 32'(frame_err), 32'(e_err[t+1]));
      chk("locked", 32'(locked), 32'(hl));
      chk("val_out", 32'(val_out), 32'(hw));
      chk("sat", 32'(sat), 32'(hs));
`ifdef R2R_PWM_DEC_STABLE_CHK_EN
      chk("r2r_err", 32'(r2r_err), 32'(hm));
`endif
    end
    frame_sync = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " val_valid"}, 32'(val_valid), 0);
    chk({tag, " val_out"}, 32'(val_out), 0);
    chk({tag, " locked"}, 32'(locked), 0);
    chk({tag, " frame_err"}, 32'(frame_err), 0);
    chk({tag, " sat"}, 32'(sat), 0);
    chk({tag, " r2r_err"}, 32'(r2r_err), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rstn = 1'b1;
    T = 0;
    add_idle(3);
    repeat (3) add_seg(16, 4'hA, 1);
    add_seg(16, 4'h3, 2);
    add_seg(16, 4'h3, 3);
    add_seg(16, 4'h3, 1);
    add_seg(7, 4'h5, 0);
    add_seg(16, 4'h6, 0);
    add_seg(16, 4'h7, 3);
    add_seg(30, 4'h9, 1);
    add_seg(16, 4'h5, 4);
    add_seg(16, 4'h5, 0);
    add_random(30);
    add_seg(16, 4'hC, 1);
    add_seg(16, 4'hD, 3);
    add_seg(9, 4'hE, 0);
    run_stream();
    #2 rstn = 1'b0;
    #1 chk_zero("async reset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    T = 0;
    syncs.delete();
    add_idle(5);
    add_random(12);
    add_seg(16, 4'h2, 0);
    add_idle(3);
    run_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
